// File: rtl/stream_demux4.sv
// Four-way valid/ready stream distributor; each output channel has its own 2-entry FIFO.
// Optional per-channel delivery counters are enabled by defining STREAM_DEMUX4_STATS_EN.
module stream_demux4_fifo #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [1:0]   count,
    output logic [W-1:0] rdata
);
    logic [1:0][W-1:0] mem;
    logic              wp, rp;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            mem   <= '0;
            wp    <= 1'b0;
            rp    <= 1'b0;
            count <= 2'd0;
        end else begin
            if (push) begin
                mem[wp] <= wdata;
                wp      <= ~wp;
            end
            if (pop)
                rp <= ~rp;
            // Simultaneous push and pop leaves occupancy unchanged.
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign rdata = mem[rp];
endmodule

module stream_demux4 #(
    parameter int DATA_BIT_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [1:0]                in_sel,
    input  logic [DATA_BIT_WIDTH-1:0] in_data,
    output logic [3:0]                out_valid,
    input  logic [3:0]                out_ready,
`ifdef STREAM_DEMUX4_STATS_EN
    output logic [15:0]               delivered0,
    output logic [15:0]               delivered1,
    output logic [15:0]               delivered2,
    output logic [15:0]               delivered3,
`endif
    output logic [DATA_BIT_WIDTH-1:0] out_data0,
    output logic [DATA_BIT_WIDTH-1:0] out_data1,
    output logic [DATA_BIT_WIDTH-1:0] out_data2,
    output logic [DATA_BIT_WIDTH-1:0] out_data3
);
    localparam int NUM_CH = 4;

    logic [NUM_CH-1:0][1:0]                cnt;
    logic [NUM_CH-1:0][DATA_BIT_WIDTH-1:0] head;
    logic [NUM_CH-1:0]                     push, pop;
    logic                                  accept;

    // Readiness depends only on registered occupancy; no bypass from out_ready.
    assign in_ready = (cnt[in_sel] != 2'd2);
    assign accept   = in_valid & in_ready;

    genvar k;
    generate
        for (k = 0; k < NUM_CH; k++) begin : g_ch
            assign push[k]      = accept && (in_sel == k[1:0]);
            assign out_valid[k] = (cnt[k] != 2'd0);
            assign pop[k]       = out_valid[k] & out_ready[k];

            stream_demux4_fifo #(.W(DATA_BIT_WIDTH)) u_fifo (
                .clk     (clk),
                .reset_n (reset_n),
                .push    (push[k]),
                .pop     (pop[k]),
                .wdata   (in_data),
                .count   (cnt[k]),
                .rdata   (head[k])
            );
        end
    endgenerate

    assign out_data0 = head[0];
    assign out_data1 = head[1];
    assign out_data2 = head[2];
    assign out_data3 = head[3];

`ifdef STREAM_DEMUX4_STATS_EN
    logic [NUM_CH-1:0][15:0] dcnt;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            dcnt <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++)
                if (pop[i] && dcnt[i] != 16'hFFFF)
                    dcnt[i] <= dcnt[i] + 16'd1;
        end
    end

    assign delivered0 = dcnt[0];
    assign delivered1 = dcnt[1];
    assign delivered2 = dcnt[2];
    assign delivered3 = dcnt[3];
`endif
endmodule

// File: tb/tb_stream_demux4.sv
// Directed self-checking bench for stream_demux4 (stats checks only when STREAM_DEMUX4_STATS_EN is defined).
module tb_stream_demux4;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_sel;
    logic [31:0] in_data;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic [31:0] od0, od1, od2, od3;
`ifdef STREAM_DEMUX4_STATS_EN
    logic [15:0] dl0, dl1, dl2, dl3;
`endif

    int vecs = 0;
    int errs = 0;

    always #5 clk = ~clk;

    stream_demux4 #(.DATA_BIT_WIDTH(32)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sel    (in_sel),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef STREAM_DEMUX4_STATS_EN
        .delivered0(dl0),
        .delivered1(dl1),
        .delivered2(dl2),
        .delivered3(dl3),
`endif
        .out_data0 (od0),
        .out_data1 (od1),
        .out_data2 (od2),
        .out_data3 (od3)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_valid(input string name, input logic [3:0] exp);
        vecs++;
        if (out_valid !== exp) begin
            errs++;
            $display("FAIL %s: out_valid=%b expected %b", name, out_valid, exp);
        end
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        in_valid  = 1'b1;
        in_sel    = 2'd1;
        in_data   = 32'hAAAA_5555;
        out_ready = 4'b0000;
        step();
        step();
        chk_valid("reset_valid", 4'b0000);
        vecs++;
        if ({od0, od1, od2, od3} !== 128'd0) begin
            errs++;
            $display("FAIL reset_data: %h %h %h %h expected all 0", od0, od1, od2, od3);
        end
        in_valid = 1'b0;
        for (int s = 0; s < 4; s++) begin
            in_sel = s[1:0];
            #1;
            vecs++;
            if (in_ready !== 1'b1) begin
                errs++;
                $display("FAIL reset_in_ready sel%0d: got %b expected 1", s, in_ready);
            end
        end
        reset_n = 1'b1;
        step();
        chk_valid("reset_release_no_push", 4'b0000);
    endtask

    task automatic test_single_route();
        out_ready = 4'b1111;
        in_valid  = 1'b1;
        in_sel    = 2'd2;
        in_data   = 32'hDEADBEEF;
        step();
        in_valid = 1'b0;
        chk_valid("single_valid", 4'b0100);
        vecs++;
        if (od2 !== 32'hDEADBEEF) begin
            errs++;
            $display("FAIL single_data: out_data2=%h expected DEADBEEF", od2);
        end
        step();
        chk_valid("single_popped", 4'b0000);
    endtask

    task automatic test_backpressure();
        logic [31:0] words [3];
        words[0] = 32'h11; words[1] = 32'h22; words[2] = 32'h33;
        out_ready = 4'b1101;
        in_valid  = 1'b1;
        in_sel    = 2'd1;
        for (int i = 0; i < 2; i++) begin
            in_data = words[i];
            #1;
            vecs++;
            if (in_ready !== 1'b1) begin
                errs++;
                $display("FAIL bp_accept%0d: in_ready=%b expected 1", i, in_ready);
            end
            step();
        end
        in_data = words[2];
        #1;
        vecs++;
        if (in_ready !== 1'b0) begin
            errs++;
            $display("FAIL bp_full: in_ready=%b expected 0", in_ready);
        end
        step();
        vecs++;
        if (od1 !== 32'h11 || out_valid !== 4'b0010) begin
            errs++;
            $display("FAIL bp_head: out_data1=%h out_valid=%b expected 11/0010", od1, out_valid);
        end
        out_ready = 4'b1111;
        #1;
        vecs++;
        if (in_ready !== 1'b0) begin
            errs++;
            $display("FAIL bp_no_bypass: in_ready=%b expected 0", in_ready);
        end
        step();
        vecs++;
        if (od1 !== 32'h22 || in_ready !== 1'b1) begin
            errs++;
            $display("FAIL bp_second: out_data1=%h in_ready=%b expected 22/1", od1, in_ready);
        end
        step();
        in_valid = 1'b0;
        vecs++;
        if (od1 !== 32'h33 || out_valid !== 4'b0010) begin
            errs++;
            $display("FAIL bp_third: out_data1=%h out_valid=%b expected 33/0010", od1, out_valid);
        end
        step();
        chk_valid("bp_drained", 4'b0000);
    endtask

    task automatic test_isolation();
        out_ready = 4'b0000;
        in_valid  = 1'b1;
        in_sel    = 2'd0;
        in_data   = 32'hA0;
        step();
        in_data = 32'hA1;
        step();
        in_data = 32'h55;
        #1;
        vecs++;
        if (in_ready !== 1'b0) begin
            errs++;
            $display("FAIL iso_ch0_full: in_ready=%b expected 0", in_ready);
        end
        in_sel = 2'd3;
        #1;
        vecs++;
        if (in_ready !== 1'b1) begin
            errs++;
            $display("FAIL iso_ch3_ready: in_ready=%b expected 1", in_ready);
        end
        step();
        in_valid = 1'b0;
        chk_valid("iso_valid", 4'b1001);
        vecs++;
        if (od3 !== 32'h55 || od0 !== 32'hA0) begin
            errs++;
            $display("FAIL iso_data: out_data3=%h out_data0=%h expected 55/A0", od3, od0);
        end
        out_ready = 4'b1001;
        step();
        chk_valid("iso_pop1", 4'b0001);
        vecs++;
        if (od0 !== 32'hA1) begin
            errs++;
            $display("FAIL iso_order: out_data0=%h expected A1", od0);
        end
        step();
        chk_valid("iso_drained", 4'b0000);
    endtask

    task automatic test_streaming();
        out_ready = 4'b1111;
        in_valid  = 1'b1;
        in_sel    = 2'd0;
        for (int i = 0; i < 100; i++) begin
            in_data = 32'(i + 1);
            #1;
            vecs++;
            if (in_ready !== 1'b1) begin
                errs++;
                $display("FAIL stream_ready%0d: in_ready=%b expected 1", i, in_ready);
            end
            step();
            vecs++;
            if (out_valid[0] !== 1'b1 || od0 !== 32'(i + 1)) begin
                errs++;
                $display("FAIL stream_data%0d: valid=%b data=%0d expected 1/%0d", i, out_valid[0], od0, i + 1);
            end
        end
        in_valid = 1'b0;
        step();
        chk_valid("stream_drained", 4'b0000);
    endtask

`ifdef STREAM_DEMUX4_STATS_EN
    task automatic test_stats();
        reset_n  = 1'b0;
        in_valid = 1'b0;
        step();
        reset_n   = 1'b1;
        out_ready = 4'b0100;
        in_valid  = 1'b1;
        in_sel    = 2'd2;
        for (int i = 0; i < 3; i++) begin
            in_data = 32'(i);
            step();
        end
        in_valid = 1'b0;
        step();
        vecs++;
        if (dl2 !== 16'd3 || dl0 !== 16'd0 || dl1 !== 16'd0 || dl3 !== 16'd0) begin
            errs++;
            $display("FAIL stats_three: %0d %0d %0d %0d expected 0 0 3 0", dl0, dl1, dl2, dl3);
        end
        out_ready = 4'b0001;
        in_valid  = 1'b1;
        in_sel    = 2'd0;
        for (int i = 0; i < 70000; i++) begin
            in_data = 32'(i);
            step();
        end
        in_valid = 1'b0;
        step();
        vecs++;
        if (dl0 !== 16'hFFFF || dl2 !== 16'd3) begin
            errs++;
            $display("FAIL stats_saturate: delivered0=%h delivered2=%0d expected FFFF/3", dl0, dl2);
        end
    endtask
`endif

    initial begin
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_sel    = 2'd0;
        in_data   = 32'd0;
        out_ready = 4'b0000;
        #2;
        test_reset();
        test_single_route();
        test_backpressure();
        test_isolation();
        test_streaming();
`ifdef STREAM_DEMUX4_STATS_EN
        test_stats();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
